// File: rtl/ccastles_pkg.sv
// Shared constants and helpers for the Crystal Castles trackball quadrature transmitter.
package ccastles_pkg;

    localparam int STEP_DIV_DEFAULT = 400;
    localparam int DELTA_W_DEFAULT  = 8;
    localparam int ACC_W_DEFAULT    = 12;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_REV  = 2'b10
    } step_e;

    function automatic int acc_max_f(input int w);
        return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
    endfunction

    function automatic int acc_min_f(input int w);
        return -(32'sd1 <<< (w - 32'sd1));
    endfunction

    localparam int ACC_MAX = acc_max_f(ACC_W_DEFAULT);
    localparam int ACC_MIN = acc_min_f(ACC_W_DEFAULT);

    // Phase to (A,B): A = p[1], B = p[1] ^ p[0]; forward order 00,01,11,10.
    function automatic logic [1:0] gray2(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

endpackage

// File: rtl/ccastles_trackball_quad_if.sv
// Host motion inputs and quadrature outputs of the trackball transmitter.
interface ccastles_trackball_quad_if #(
    parameter int DELTA_W = 8
);
    logic                      delta_valid;
    logic signed [DELTA_W-1:0] delta_x;
    logic signed [DELTA_W-1:0] delta_y;
    logic                      flip;
    logic                      qx_a;
    logic                      qx_b;
    logic                      qy_a;
    logic                      qy_b;
    logic                      busy;

    modport master (
        output delta_valid, delta_x, delta_y, flip,
        input  qx_a, qx_b, qy_a, qy_b, busy
    );

    modport slave (
        input  delta_valid, delta_x, delta_y, flip,
        output qx_a, qx_b, qy_a, qy_b, busy
    );
endinterface

// File: rtl/ccastles_quad_axis.sv
// One trackball axis: saturating pending-step accumulator, phase counter and
// registered Gray-coded quadrature output.
module ccastles_quad_axis
    import ccastles_pkg::*;
#(
    parameter int DELTA_W = 8,
    parameter int ACC_W   = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick_i,
    input  logic                      delta_valid_i,
    input  logic signed [DELTA_W-1:0] delta_i,
    input  logic                      flip_i,
    output logic                      a_o,
    output logic                      b_o,
    output logic                      nonzero_o
);

    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(acc_max_f(ACC_W));
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(acc_min_f(ACC_W));

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]              phase_q, phase_d;
    logic [1:0]              ab_q, ab_d;
    step_e                   step_s;
    logic signed [SUM_W-1:0] acc_ext_s, delta_ext_s, step_ext_s, sum_s;

    // Step decision and phase advance; flip only reverses the phase direction.
    always_comb begin
        step_s  = STEP_NONE;
        phase_d = phase_q;
        if (tick_i) begin
            if (acc_q[ACC_W-1]) begin
                step_s = STEP_REV;
            end else if (|acc_q) begin
                step_s = STEP_FWD;
            end else begin
                step_s = STEP_NONE;
            end
        end else begin
            step_s = STEP_NONE;
        end
        case (step_s)
            STEP_FWD: phase_d = flip_i ? (phase_q - 2'd1) : (phase_q + 2'd1);
            STEP_REV: phase_d = flip_i ? (phase_q + 2'd1) : (phase_q - 2'd1);
            default:  phase_d = phase_q;
        endcase
        ab_d = gray2(phase_d);
    end

    // Full-precision accumulator update with saturation to the ACC_W range.
    always_comb begin
        acc_ext_s   = {{2{acc_q[ACC_W-1]}}, acc_q};
        delta_ext_s = {SUM_W{1'b0}};
        if (delta_valid_i) begin
            delta_ext_s = {{(SUM_W-DELTA_W){delta_i[DELTA_W-1]}}, delta_i};
        end else begin
            delta_ext_s = {SUM_W{1'b0}};
        end
        case (step_s)
            STEP_FWD: step_ext_s = {{(SUM_W-1){1'b0}}, 1'b1};
            STEP_REV: step_ext_s = {SUM_W{1'b1}};
            default:  step_ext_s = {SUM_W{1'b0}};
        endcase
        sum_s = acc_ext_s + delta_ext_s - step_ext_s;
        if (sum_s > SUM_MAX) begin
            acc_d = SUM_MAX[ACC_W-1:0];
        end else if (sum_s < SUM_MIN) begin
            acc_d = SUM_MIN[ACC_W-1:0];
        end else begin
            acc_d = sum_s[ACC_W-1:0];
        end
    end

    // Axis state registers; outputs come straight from flops so they never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= {ACC_W{1'b0}};
            phase_q <= 2'b00;
            ab_q    <= 2'b00;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            ab_q    <= ab_d;
        end
    end

    assign a_o       = ab_q[1];
    assign b_o       = ab_q[0];
    assign nonzero_o = |acc_q;

endmodule

// File: rtl/ccastles_trackball_quad.sv
// Trackball quadrature transmitter: shared step-rate tick, two axes and busy flag.
module ccastles_trackball_quad
    import ccastles_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEFAULT,
    parameter int DELTA_W  = DELTA_W_DEFAULT,
    parameter int ACC_W    = ACC_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    ccastles_trackball_quad_if.slave  bus
);

    localparam int CNT_W = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_s;
    logic             busy_q, busy_d;
    logic             nz_x_s, nz_y_s;

    // Tick counter wraps after STEP_DIV cycles; tick marks the last count.
    always_comb begin
        tick_s = (cnt_q == CNT_LAST);
        if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        busy_d = nz_x_s | nz_y_s;
    end

    // Tick counter and busy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    ccastles_quad_axis #(
        .DELTA_W (DELTA_W),
        .ACC_W   (ACC_W)
    ) u_axis_x (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick_i        (tick_s),
        .delta_valid_i (bus.delta_valid),
        .delta_i       (bus.delta_x),
        .flip_i        (bus.flip),
        .a_o           (bus.qx_a),
        .b_o           (bus.qx_b),
        .nonzero_o     (nz_x_s)
    );

    ccastles_quad_axis #(
        .DELTA_W (DELTA_W),
        .ACC_W   (ACC_W)
    ) u_axis_y (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick_i        (tick_s),
        .delta_valid_i (bus.delta_valid),
        .delta_i       (bus.delta_y),
        .flip_i        (bus.flip),
        .a_o           (bus.qy_a),
        .b_o           (bus.qy_b),
        .nonzero_o     (nz_y_s)
    );

    assign bus.busy = busy_q;

endmodule

// File: tb/tb_ccastles_trackball_quad.sv
// Randomised scoreboard bench for the trackball quadrature transmitter.
module tb_ccastles_trackball_quad;

    localparam int SD   = 4;
    localparam int DW   = 8;
    localparam int AW   = 12;
    localparam int AMAX = 2047;
    localparam int AMIN = -2048;

    typedef struct {
        logic [1:0] ab;
        longint     stamp;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ccastles_trackball_quad_if #(.DELTA_W(DW)) bus();

    ccastles_trackball_quad #(
        .STEP_DIV (SD),
        .DELTA_W  (DW),
        .ACC_W    (AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   ax = 0, ay = 0, px = 0, py = 0, rcyc = 0;
    logic busy_m = 1'b0;
    exp_t qx[$];
    exp_t qy[$];
    logic [1:0] gray_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    function automatic int dir_of(input int a);
        return (a > 0) ? 1 : ((a < 0) ? -1 : 0);
    endfunction

    // Reference model: one step per axis on every SD-th cycle, phase walks the Gray table.
    initial begin
        int sx, sy, stepx, stepy;
        logic tick;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                ax = 0; ay = 0; px = 0; py = 0; rcyc = 0; busy_m = 1'b0;
                qx.delete(); qy.delete();
            end else begin
                tick   = ((rcyc % SD) == SD - 1);
                stepx  = tick ? dir_of(ax) : 0;
                stepy  = tick ? dir_of(ay) : 0;
                busy_m = (ax != 0) || (ay != 0);
                ax = sat(ax + (bus.delta_valid ? int'(bus.delta_x) : 0) - stepx);
                ay = sat(ay + (bus.delta_valid ? int'(bus.delta_y) : 0) - stepy);
                if (stepx != 0) begin
                    sx = bus.flip ? -stepx : stepx;
                    px = (px + sx + 4) % 4;
                    qx.push_back('{gray_tbl[px], longint'($time)});
                end
                if (stepy != 0) begin
                    sy = bus.flip ? -stepy : stepy;
                    py = (py + sy + 4) % 4;
                    qy.push_back('{gray_tbl[py], longint'($time)});
                end
                rcyc++;
            end
        end
    end

    // Monitor: every output edge must match the next queued step, on the expected clock edge.
    initial begin
        logic [1:0] prev_x, prev_y, cur;
        exp_t e;
        prev_x = 2'b00;
        prev_y = 2'b00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_x = 2'b00;
                prev_y = 2'b00;
            end else begin
                chk("busy", 32'(bus.busy), 32'(busy_m));
                cur = {bus.qx_a, bus.qx_b};
                if (cur != prev_x) begin
                    if (qx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL qx_unexpected: got %b expected no change", cur);
                    end else begin
                        e = qx.pop_front();
                        chk("qx_value", 32'(cur), 32'(e.ab));
                        chk("qx_time", 32'($time - e.stamp), 32'd5);
                    end
                    prev_x = cur;
                end
                cur = {bus.qy_a, bus.qy_b};
                if (cur != prev_y) begin
                    if (qy.size() == 0) begin
                        total++; bad++;
                        $display("FAIL qy_unexpected: got %b expected no change", cur);
                    end else begin
                        e = qy.pop_front();
                        chk("qy_value", 32'(cur), 32'(e.ab));
                        chk("qy_time", 32'($time - e.stamp), 32'd5);
                    end
                    prev_y = cur;
                end
            end
        end
    end

    task automatic chk_zero(input string name);
        chk({name, "_q"}, 32'({bus.qx_a, bus.qx_b, bus.qy_a, bus.qy_b}), 32'd0);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_accx"}, 32'(dut.u_axis_x.acc_q), 32'd0);
        chk({name, "_accy"}, 32'(dut.u_axis_y.acc_q), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drive(input logic v, input int dx, input int dy);
        bus.delta_valid = v;
        bus.delta_x     = DW'(dx);
        bus.delta_y     = DW'(dy);
    endtask

    // Caller sits on a negedge; sample happens at the next posedge.
    task automatic strobe(input int dx, input int dy);
        drive(1'b1, dx, dy);
        @(negedge clk);
        drive(1'b0, 0, 0);
    endtask

    task automatic go_pre_tick(input logic want_tick);
        int n = 0;
        @(negedge clk);
        while ((((rcyc % SD) == SD - 1) != want_tick) && n < 4 * SD) begin
            @(negedge clk);
            n++;
        end
        chk("align_bound", 32'(n < 4 * SD), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((ax != 0 || ay != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", 32'(n < 20000), 32'd1);
        repeat (SD + 2) @(negedge clk);
        chk("drain_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        drive(1'b0, 0, 0);
        bus.flip = 1'b0;
        #1;
        chk_zero("por");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle for ten ticks: no edges, busy low.
        repeat (10 * SD) @(negedge clk);
        chk("idle_q", 32'({bus.qx_a, bus.qx_b, bus.qy_a, bus.qy_b}), 32'd0);

        // Forward x by 3, then reverse y by 2.
        @(negedge clk);
        strobe(3, 0);
        drain();
        chk("fwd_x_final", 32'({bus.qx_a, bus.qx_b}), 32'd2);
        chk("fwd_x_qy", 32'({bus.qy_a, bus.qy_b}), 32'd0);
        @(negedge clk);
        strobe(0, -2);
        drain();
        chk("rev_y_final", 32'({bus.qy_a, bus.qy_b}), 32'd3);

        // Saturation: twenty +127 strobes, then -128 on a non-tick edge.
        do_reset();
        @(negedge clk);
        repeat (20) begin
            drive(1'b1, 127, 0);
            @(negedge clk);
        end
        chk("sat_max", 32'(dut.u_axis_x.acc_q), 32'(AMAX));
        while ((rcyc % SD) == SD - 1) begin
            drive(1'b1, 127, 0);
            @(negedge clk);
        end
        strobe(-128, 0);
        chk("sat_minus", 32'(dut.u_axis_x.acc_q), 32'd1919);
        chk("sat_model", 32'(dut.u_axis_x.acc_q), 32'(ax));

        // Reset dropped between edges while motion is pending.
        repeat (SD + 1) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Delta and step in the same cycle.
        go_pre_tick(1'b0);
        strobe(1, 0);
        go_pre_tick(1'b1);
        chk("simul_pre", 32'(dut.u_axis_x.acc_q), 32'd1);
        strobe(5, 0);
        chk("simul_acc", 32'(dut.u_axis_x.acc_q), 32'd5);
        chk("simul_q", 32'({bus.qx_a, bus.qx_b}), 32'd1);
        drain();

        // Flip reverses the sequence but not the bookkeeping.
        do_reset();
        bus.flip = 1'b1;
        @(negedge clk);
        strobe(2, 0);
        drain();
        chk("flip_final", 32'({bus.qx_a, bus.qx_b}), 32'd3);
        chk("flip_acc", 32'(dut.u_axis_x.acc_q), 32'd0);

        // Random motion with random flip and spacing.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.flip = 1'($urandom_range(0, 1));
            strobe(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();
        chk("rand_accx", 32'(dut.u_axis_x.acc_q), 32'd0);
        chk("qx_left", 32'(qx.size()), 32'd0);
        chk("qy_left", 32'(qy.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
